// File: rtl/ula_arbiter.sv
// ula_arbiter: round-robin arbiter sharing one add/sub/shift ULA between two
// requesters. The winner's operands are latched, the ULA runs for EXEC_CYCLES
// cycles, and the registered result is returned with a one-cycle done pulse.
//
// Ports
//   iCLK, iRST_N            clock (rising edge), async active-low reset
//   iREQ0/iA0/iB0/iSEL0     requester 0: level request, operands, op select
//   iREQ1/iA1/iB1/iSEL1     requester 1: level request, operands, op select
//                           op select: 00 add, 01 sub, 10 A>>B, 11 A<<B
//   oGNT0/oGNT1             1-cycle pulse: that requester's operands captured
//   oDONE0/oDONE1           1-cycle pulse: oRES valid for that requester
//   oRES                    last result, held until the next done pulse
//   oBUSY                   high while an operation is executing or completing
module ula_arbiter #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic             iCLK,
  input  logic             iRST_N,
  input  logic             iREQ0,
  input  logic [WIDTH-1:0] iA0,
  input  logic [WIDTH-1:0] iB0,
  input  logic [1:0]       iSEL0,
  input  logic             iREQ1,
  input  logic [WIDTH-1:0] iA1,
  input  logic [WIDTH-1:0] iB1,
  input  logic [1:0]       iSEL1,
  output logic             oGNT0,
  output logic             oGNT1,
  output logic             oDONE0,
  output logic             oDONE1,
  output logic [WIDTH-1:0] oRES,
  output logic             oBUSY
);

  localparam int unsigned CNT_W = (EXEC_CYCLES > 1) ? $clog2(EXEC_CYCLES) : 1;

  // Shift amounts at or beyond this value flush the operand to zero.
  localparam logic [WIDTH:0] SHIFT_LIM = (WIDTH+1)'(WIDTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_SHR = 2'b10;

  // Latched operation payload of the granted requester.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [1:0]       sel;
  } op_t;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             ptr_q,   ptr_d;
  logic             id_q,    id_d;
  op_t              op_q,    op_d;
  logic             gnt0_q,  gnt0_d;
  logic             gnt1_q,  gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic [WIDTH-1:0] res_q,   res_d;
  logic             busy_q,  busy_d;

  logic             win_c;
  logic             shift_oob_c;
  logic [WIDTH-1:0] ula_res_c;

  // Winner selection: a sole requester wins, a tie goes to the pointer.
  always_comb begin
    win_c = iREQ1;
    if (iREQ0 && iREQ1) begin
      win_c = ptr_q;
    end
  end

  // Shared ULA operating on the latched operands.
  always_comb begin
    shift_oob_c = ({1'b0, op_q.b} >= SHIFT_LIM);
    ula_res_c   = '0;
    case (op_q.sel)
      OP_ADD:  ula_res_c = op_q.a + op_q.b;
      OP_SUB:  ula_res_c = op_q.a - op_q.b;
      OP_SHR:  ula_res_c = shift_oob_c ? '0 : (op_q.a >> op_q.b);
      default: ula_res_c = shift_oob_c ? '0 : (op_q.a << op_q.b);
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_d    = op_q;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    done0_d = 1'b0;
    done1_d = 1'b0;
    res_d   = res_q;
    busy_d  = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (iREQ0 || iREQ1) begin
          id_d    = win_c;
          op_d    = win_c ? op_t'{a: iA1, b: iB1, sel: iSEL1}
                          : op_t'{a: iA0, b: iB0, sel: iSEL0};
          gnt0_d  = ~win_c;
          gnt1_d  = win_c;
          cnt_d   = CNT_W'(EXEC_CYCLES - 1);
          busy_d  = 1'b1;
          state_d = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (cnt_q == '0) begin
          res_d   = ula_res_c;
          done0_d = ~id_q;
          done1_d = id_q;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_DONE: begin
        // Pointer always moves away from the requester just served.
        ptr_d   = ~id_q;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= 1'b0;
      id_q    <= 1'b0;
      op_q    <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      res_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_q    <= op_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      done0_q <= done0_d;
      done1_q <= done1_d;
      res_q   <= res_d;
      busy_q  <= busy_d;
    end
  end

  assign oGNT0  = gnt0_q;
  assign oGNT1  = gnt1_q;
  assign oDONE0 = done0_q;
  assign oDONE1 = done1_q;
  assign oRES   = res_q;
  assign oBUSY  = busy_q;

endmodule
